// File: rtl/sum_serial_nibble.sv
// Nibble-serial adder: one 4-bit add stage, a registered inter-nibble
// carry, and a valid/ready handshake on both the operand and result sides.

module Sum_com4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

module sum_serial_nibble #(
    parameter int NIBBLES = 2
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Valid,
    output logic                 o_Ready,
    input  logic [4*NIBBLES-1:0] i_bit1,
    input  logic [4*NIBBLES-1:0] i_bit2,
    input  logic                 i_Carry,
    output logic                 o_Valid,
    input  logic                 i_Ready,
    output logic [4*NIBBLES-1:0] o_Suma,
    output logic                 o_Carry,
    output logic                 o_Busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    part;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic [3:0]      nsum;
    logic            ncout;
    logic [W-1:0]    next_part;
    logic            last;

    Sum_com4b u_add (
        .a   (a_sh[3:0]),
        .b   (b_sh[3:0]),
        .cin (carry),
        .sum (nsum),
        .cout(ncout)
    );

    // New nibble sums enter at the top; after NIBBLES steps the word is aligned.
    generate
        if (NIBBLES == 1) begin : g_one
            assign next_part = nsum;
        end else begin : g_many
            assign next_part = {nsum, part[W-1:4]};
        end
    endgenerate

    assign last = (cnt == CW'(NIBBLES - 1));

    // Handshake flags depend only on state (and reset for ready).
    assign o_Ready = (state == IDLE) && !i_Rst;
    assign o_Valid = (state == DONE);
    assign o_Busy  = (state != IDLE);

    // Control FSM with operand shifters, carry chain and result registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            part    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            o_Suma  <= '0;
            o_Carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_Valid) begin
                        a_sh  <= i_bit1;
                        b_sh  <= i_bit2;
                        carry <= i_Carry;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    part  <= next_part;
                    carry <= ncout;
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        o_Suma  <= next_part;
                        o_Carry <= ncout;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (i_Ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_serial_nibble.sv
// Bench for sum_serial_nibble: directed vectors and random sweeps on
// three widths, with queued expectations checked by per-instance monitors.

module tb_sum_serial_nibble;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst;
    logic        rst_b;

    // NIBBLES=2 instance
    logic        v2, rdy2, ov2, ir2, ci2, oc2, bz2;
    logic [7:0]  a2, b2, s2;
    logic [8:0]  q2[$];

    // NIBBLES=1 instance
    logic        v1, rdy1, ov1, ir1, ci1, oc1, bz1;
    logic [3:0]  a1, b1, s1;
    logic [4:0]  q1[$];

    // NIBBLES=4 instance
    logic        v4, rdy4, ov4, ir4, ci4, oc4, bz4;
    logic [15:0] a4, b4, s4;
    logic [16:0] q4[$];

    bit done1 = 0;
    bit done4 = 0;

    sum_serial_nibble #(.NIBBLES(2)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(v2), .o_Ready(rdy2),
        .i_bit1(a2), .i_bit2(b2), .i_Carry(ci2), .o_Valid(ov2),
        .i_Ready(ir2), .o_Suma(s2), .o_Carry(oc2), .o_Busy(bz2)
    );

    sum_serial_nibble #(.NIBBLES(1)) dut1 (
        .i_Clk(clk), .i_Rst(rst_b), .i_Valid(v1), .o_Ready(rdy1),
        .i_bit1(a1), .i_bit2(b1), .i_Carry(ci1), .o_Valid(ov1),
        .i_Ready(ir1), .o_Suma(s1), .o_Carry(oc1), .o_Busy(bz1)
    );

    sum_serial_nibble #(.NIBBLES(4)) dut4 (
        .i_Clk(clk), .i_Rst(rst_b), .i_Valid(v4), .o_Ready(rdy4),
        .i_bit1(a4), .i_bit2(b4), .i_Carry(ci4), .o_Valid(ov4),
        .i_Ready(ir4), .o_Suma(s4), .o_Carry(oc4), .o_Busy(bz4)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per result handshake.
    always @(negedge clk) begin
        if (ov2 && ir2) begin
            if (q2.size() == 0) chk("n2_unexpected", 32'(ov2), 32'(0));
            else chk("n2_result", 32'({oc2, s2}), 32'(q2.pop_front()));
        end
        if (ov1 && ir1) begin
            if (q1.size() == 0) chk("n1_unexpected", 32'(ov1), 32'(0));
            else chk("n1_result", 32'({oc1, s1}), 32'(q1.pop_front()));
        end
        if (ov4 && ir4) begin
            if (q4.size() == 0) chk("n4_unexpected", 32'(ov4), 32'(0));
            else chk("n4_result", 32'({oc4, s4}), 32'(q4.pop_front()));
        end
    end

    task automatic wait_ready2();
        int n = 0;
        while (!rdy2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy2) chk("n2_ready_timeout", 32'(rdy2), 32'(1));
    endtask

    // Issue one operation; returns after o_Valid rises (or times out).
    task automatic op2(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [8:0] exp);
        int n;
        wait_ready2();
        a2 = a; b2 = b; ci2 = c; v2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0;
        q2.push_back(exp);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ov2 && n < 10);
        chk("n2_latency", 32'(n), 32'(2));
    endtask

    task automatic after_hs2();
        @(posedge clk); #1;
        chk("n2_valid_drop", 32'(ov2), 32'(0));
        chk("n2_ready_back", 32'(rdy2), 32'(1));
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        int         n;
        rst = 1'b1; v2 = 0; ir2 = 1; a2 = 0; b2 = 0; ci2 = 0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_ready", 32'(rdy2), 32'(0));
        chk("rst_valid", 32'(ov2), 32'(0));
        chk("rst_suma", 32'(s2), 32'(0));
        chk("rst_carry", 32'(oc2), 32'(0));
        chk("rst_busy", 32'(bz2), 32'(0));
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_ready", 32'(rdy2), 32'(1));

        op2(8'h22, 8'h22, 1'b0, 9'h044);
        after_hs2();
        op2(8'h0F, 8'h01, 1'b0, 9'h010);
        after_hs2();
        op2(8'h7A, 8'h86, 1'b0, 9'h100);
        after_hs2();
        op2(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        after_hs2();
        op2(8'h00, 8'h00, 1'b1, 9'h001);
        after_hs2();

        // Backpressure with a competing request while DONE.
        ir2 = 1'b0;
        op2(8'h5A, 8'h33, 1'b0, 9'h08D);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(ov2), 32'(1));
            chk("bp_suma", 32'(s2), 32'(8'h8D));
            chk("bp_carry", 32'(oc2), 32'(0));
            chk("bp_ready", 32'(rdy2), 32'(0));
            if (i == 2) begin
                a2 = 8'h11; b2 = 8'h11; ci2 = 1'b1; v2 = 1'b1;
            end else begin
                v2 = 1'b0;
            end
            @(posedge clk); #1;
        end
        v2 = 1'b0;
        ir2 = 1'b1;
        after_hs2();
        chk("bp_no_accept", 32'(bz2), 32'(0));

        // Asynchronous reset while holding a result.
        ir2 = 1'b0;
        op2(8'h22, 8'h11, 1'b0, 9'h033);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ov2), 32'(0));
        chk("arst_suma", 32'(s2), 32'(0));
        chk("arst_carry", 32'(oc2), 32'(0));
        chk("arst_ready", 32'(rdy2), 32'(0));
        q2.delete();
        #3 rst = 1'b0;
        ir2 = 1'b1;
        @(posedge clk); #1;
        chk("arst_rel_ready", 32'(rdy2), 32'(1));

        // Reset one edge after accept: no result may appear.
        a2 = 8'h44; b2 = 8'h44; ci2 = 1'b0; v2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #2 rst = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ov2) n++;
        end
        chk("abort_no_valid", 32'(n), 32'(0));
        op2(8'h12, 8'h34, 1'b0, 9'h046);
        after_hs2();

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            op2(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'h00, rc});
        end
        @(posedge clk); #1;

        n = 0;
        while (!(done1 && done4) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk("sweeps_done", 32'(done1 && done4), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        chk("q2_empty", 32'(q2.size()), 32'(0));
        chk("q1_empty", 32'(q1.size()), 32'(0));
        chk("q4_empty", 32'(q4.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst_b = 1'b1;
        #12 rst_b = 1'b0;
    end

    // NIBBLES=1 random sweep.
    initial begin
        logic [3:0] ra, rb;
        logic       rc;
        int         n;
        v1 = 0; ir1 = 1; a1 = 0; b1 = 0; ci1 = 0;
        @(negedge rst_b);
        @(posedge clk); #1;
        for (int i = 0; i < 200; i++) begin
            n = 0;
            while (!rdy1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
            a1 = ra; b1 = rb; ci1 = rc; v1 = 1'b1;
            @(posedge clk); #1;
            v1 = 1'b0;
            q1.push_back({1'b0, ra} + {1'b0, rb} + {4'h0, rc});
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!ov1 && n < 10);
            chk("n1_latency", 32'(n), 32'(1));
        end
        @(posedge clk); #1;
        done1 = 1;
    end

    // NIBBLES=4 random sweep.
    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        int          n;
        v4 = 0; ir4 = 1; a4 = 0; b4 = 0; ci4 = 0;
        @(negedge rst_b);
        @(posedge clk); #1;
        for (int i = 0; i < 200; i++) begin
            n = 0;
            while (!rdy4 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            a4 = ra; b4 = rb; ci4 = rc; v4 = 1'b1;
            @(posedge clk); #1;
            v4 = 1'b0;
            q4.push_back({1'b0, ra} + {1'b0, rb} + {16'h0, rc});
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!ov4 && n < 10);
            chk("n4_latency", 32'(n), 32'(4));
        end
        @(posedge clk); #1;
        done4 = 1;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
